// File: rtl/io_bus_arbiter.sv
// Round-robin arbiter sharing the memory_io port among NUM_REQ requesters.
// Tracks in-flight reads through the fixed memory_io pipeline and steers read data back to the issuer.
module io_bus_arbiter #(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned IO_LATENCY = 2
) (
  input  logic                  main_clk,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ-1:0]    req_write,
  input  logic [NUM_REQ-1:0]    req_byte,
  input  logic [NUM_REQ*32-1:0] req_addr,
  input  logic [NUM_REQ*16-1:0] req_wdata,
  output logic [NUM_REQ-1:0]    rsp_valid,
  output logic [15:0]           rsp_data,
  output logic [31:0]           address_out_io,
  output logic [15:0]           data_in_io,
  output logic [1:0]            control_out_io,
  input  logic [15:0]           data_out_io
);

  localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned TAGS = IO_LATENCY + 1;

  logic [ID_W-1:0] ptr;
  logic [ID_W-1:0] gnt_id;
  logic            found;
  logic            grant;
  logic [31:0]     sel_addr;
  logic [15:0]     sel_wdata;
  logic            sel_write;
  logic            sel_byte;

  logic [TAGS-1:0] tag_v;
  logic [ID_W-1:0] tag_id [TAGS];

  // Winner search: the lowest valid index at or above ptr overrides any wrapped (below ptr) candidate.
  always_comb begin
    found  = 1'b0;
    gnt_id = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k] && (ID_W'(k) < ptr)) begin
        found  = 1'b1;
        gnt_id = ID_W'(k);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[k] && (ID_W'(k) >= ptr)) begin
        found  = 1'b1;
        gnt_id = ID_W'(k);
      end
    end
  end

  assign grant = found & ~reset;

  // Winner payload mux and one-hot accept.
  always_comb begin
    sel_addr  = '0;
    sel_wdata = '0;
    sel_write = 1'b0;
    sel_byte  = 1'b0;
    req_ready = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (gnt_id == ID_W'(k)) begin
        sel_addr  = req_addr[32*k +: 32];
        sel_wdata = req_wdata[16*k +: 16];
        sel_write = req_write[k];
        sel_byte  = req_byte[k];
        req_ready[k] = grant;
      end
    end
  end

  always_ff @(posedge main_clk or posedge reset) begin
    if (reset) begin
      ptr            <= '0;
      address_out_io <= '0;
      data_in_io     <= '0;
      control_out_io <= 2'b00;
      rsp_valid      <= '0;
      rsp_data       <= '0;
      tag_v          <= '0;
      for (int i = 0; i < TAGS; i++) tag_id[i] <= '0;
    end else begin
      control_out_io <= grant ? {sel_write, sel_byte} : 2'b00;
      if (grant) begin
        address_out_io <= sel_addr;
        data_in_io     <= sel_wdata;
        ptr            <= (gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : gnt_id + ID_W'(1);
      end

      // Tag i describes the access that left the arbiter i+1 cycles ago.
      tag_v     <= {tag_v[TAGS-2:0], grant & ~sel_write};
      tag_id[0] <= gnt_id;
      for (int i = 1; i < TAGS; i++) tag_id[i] <= tag_id[i-1];

      rsp_valid <= '0;
      if (tag_v[TAGS-1]) begin
        rsp_valid[tag_id[TAGS-1]] <= 1'b1;
        rsp_data                  <= data_out_io;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Randomized scoreboard bench for io_bus_arbiter with a behavioural memory_io model.
module tb_io_bus_arbiter;

  localparam int NUM_REQ    = 2;
  localparam int IO_LATENCY = 2;
  localparam int RSP_LAT    = IO_LATENCY + 2;

  logic                  main_clk;
  logic                  reset;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ-1:0]    req_write;
  logic [NUM_REQ-1:0]    req_byte;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*16-1:0] req_wdata;
  logic [NUM_REQ-1:0]    rsp_valid;
  logic [15:0]           rsp_data;
  logic [31:0]           address_out_io;
  logic [15:0]           data_in_io;
  logic [1:0]            control_out_io;
  logic [15:0]           data_out_io;

  io_bus_arbiter #(.NUM_REQ(NUM_REQ), .IO_LATENCY(IO_LATENCY)) dut (
    .main_clk       (main_clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_byte       (req_byte),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .rsp_valid      (rsp_valid),
    .rsp_data       (rsp_data),
    .address_out_io (address_out_io),
    .data_in_io     (data_in_io),
    .control_out_io (control_out_io),
    .data_out_io    (data_out_io)
  );

  typedef struct {
    bit          wr;
    bit          by;
    logic [31:0] addr;
    logic [15:0] wdata;
  } txn_t;

  typedef struct {
    int          id;
    logic [15:0] data;
    int          due;
  } rsp_t;

  txn_t rq [NUM_REQ][$];
  rsp_t sb [$];

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int mptr  = 0;
  int waits [NUM_REQ];
  bit          chk_issue = 0;
  logic [1:0]  exp_ctl   = 2'b00;
  logic [31:0] last_addr = '0;
  logic [15:0] last_data = '0;
  logic [31:0] io_pipe [IO_LATENCY];

  initial main_clk = 1'b0;
  always #5 main_clk = ~main_clk;
  always @(posedge main_clk) cyc <= cyc + 1;

  // Memory contents as seen by reads: one fixed word plus an address hash elsewhere.
  function automatic logic [15:0] mem_data(input logic [31:0] a);
    if (a == 32'h0400_0000) return 16'h1234;
    return a[15:0] ^ {a[23:16], a[31:24]} ^ 16'h5a3c;
  endfunction

  // memory_io: data for the address presented in C1 appears on data_out_io during C1+IO_LATENCY.
  always @(posedge main_clk) begin
    io_pipe[0] <= address_out_io;
    for (int i = 1; i < IO_LATENCY; i++) io_pipe[i] <= io_pipe[i-1];
  end
  assign data_out_io = mem_data(io_pipe[IO_LATENCY-1]);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Round-robin rule: first valid index searching upward from ptr, wrapping.
  function automatic int pick(input logic [NUM_REQ-1:0] v, input int p);
    for (int j = 0; j < NUM_REQ; j++)
      if (v[(p + j) % NUM_REQ]) return (p + j) % NUM_REQ;
    return -1;
  endfunction

  function automatic txn_t rand_txn();
    txn_t t;
    t.wr    = 1'($urandom_range(1));
    t.by    = 1'($urandom_range(1));
    t.addr  = $urandom;
    t.wdata = 16'($urandom);
    return t;
  endfunction

  function automatic txn_t mk(input bit wr, input bit by, input logic [31:0] a, input logic [15:0] d);
    txn_t t;
    t.wr = wr; t.by = by; t.addr = a; t.wdata = d;
    return t;
  endfunction

  // One bus cycle: check last issue, present requests, check grant, advance the model.
  task automatic step(input int p_new);
    int   k;
    txn_t t;
    @(negedge main_clk);
    if (chk_issue) begin
      chk("control_out_io", 64'(control_out_io), 64'(exp_ctl));
      chk("address_out_io", 64'(address_out_io), 64'(last_addr));
      chk("data_in_io",     64'(data_in_io),     64'(last_data));
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rq[i].size() == 0 && int'($urandom_range(99)) < p_new) rq[i].push_back(rand_txn());
      if (rq[i].size() > 0) begin
        t = rq[i][0];
        req_valid[i] = 1'b1;
      end else begin
        t = rand_txn();
        req_valid[i] = 1'b0;
      end
      req_write[i]          = t.wr;
      req_byte[i]           = t.by;
      req_addr[32*i +: 32]  = t.addr;
      req_wdata[16*i +: 16] = t.wdata;
    end
    #1;
    k = pick(req_valid, mptr);
    chk("req_ready", 64'(req_ready), (k >= 0) ? (64'd1 << k) : 64'd0);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_valid[i] && req_ready[i]) begin
        chk("max_wait_ok", 64'(waits[i] <= NUM_REQ - 1), 64'd1);
        waits[i] = 0;
      end else if (req_valid[i]) begin
        waits[i]++;
      end
    end
    if (k >= 0) begin
      t = rq[k].pop_front();
      exp_ctl   = {t.wr, t.by};
      last_addr = t.addr;
      last_data = t.wdata;
      if (!t.wr) sb.push_back('{id: k, data: mem_data(t.addr), due: cyc + RSP_LAT});
      mptr = (k + 1) % NUM_REQ;
    end else begin
      exp_ctl = 2'b00;
    end
    chk_issue = 1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0);
  endtask

  // Reset for hold cycles with garbage requests; everything in flight is forgotten.
  task automatic do_reset(input int hold);
    @(negedge main_clk);
    #2;
    reset = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) begin
      rq[i].delete();
      waits[i] = 0;
    end
    sb.delete();
    mptr = 0; last_addr = '0; last_data = '0; exp_ctl = 2'b00;
    for (int c = 0; c < hold; c++) begin
      if (c > 0) @(negedge main_clk);
      req_valid = NUM_REQ'($urandom) | NUM_REQ'(1);
      req_addr  = {NUM_REQ{$urandom}};
      req_write = NUM_REQ'($urandom);
      #1;
      chk("rst_req_ready",  64'(req_ready),      64'd0);
      chk("rst_rsp_valid",  64'(rsp_valid),      64'd0);
      chk("rst_rsp_data",   64'(rsp_data),       64'd0);
      chk("rst_address",    64'(address_out_io), 64'd0);
      chk("rst_data_in",    64'(data_in_io),     64'd0);
      chk("rst_control",    64'(control_out_io), 64'd0);
    end
    @(negedge main_clk);
    #2;
    reset     = 1'b0;
    req_valid = '0;
    chk_issue = 1;
  endtask

  // Scoreboard monitor: every response must match the oldest outstanding read, on its due cycle.
  always @(negedge main_clk) begin
    if (!reset) begin
      while (sb.size() > 0 && sb[0].due < cyc) begin
        n_cmp++;
        n_err++;
        $display("FAIL rsp_missing: id %0d due cyc %0d, actual none required rsp_valid", sb[0].id, sb[0].due);
        void'(sb.pop_front());
      end
      if (rsp_valid != '0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rsp_unexpected @cyc %0d: actual rsp_valid %0h required 0", cyc, rsp_valid);
        end else begin
          rsp_t e;
          e = sb.pop_front();
          chk("rsp_valid", 64'(rsp_valid), 64'd1 << e.id);
          chk("rsp_data",  64'(rsp_data),  64'(e.data));
          chk("rsp_cycle", 64'(cyc),       64'(e.due));
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_byte  = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) waits[i] = 0;

    do_reset(2);
    idle(10);

    // Single read of the fixed word.
    rq[0].push_back(mk(1'b0, 1'b0, 32'h0400_0000, 16'h0000));
    step(0);
    idle(6);

    // Word write from requester 1: no response expected.
    rq[1].push_back(mk(1'b1, 1'b0, 32'h0400_0002, 16'h0ABC));
    step(0);
    idle(6);

    // Read / write / read back-to-back: responses two cycles apart.
    rq[0].push_back(mk(1'b0, 1'b0, 32'h0000_1000, 16'h0000));
    rq[1].push_back(mk(1'b1, 1'b1, 32'h0000_2000, 16'h00EE));
    rq[1].push_back(mk(1'b0, 1'b1, 32'h0000_3000, 16'h0000));
    repeat (3) step(0);
    idle(6);

    // Continuous contention, then mixed random traffic.
    repeat (40) step(100);
    repeat (300) step(40);

    // Reset with three reads in flight.
    idle(RSP_LAT + 2);
    rq[0].push_back(mk(1'b0, 1'b0, 32'h0000_0100, 16'h0000));
    rq[0].push_back(mk(1'b0, 1'b1, 32'h0000_0102, 16'h0000));
    rq[1].push_back(mk(1'b0, 1'b0, 32'h0000_0200, 16'h0000));
    repeat (3) step(0);
    do_reset(2);
    idle(6);

    repeat (200) step(60);
    idle(RSP_LAT + 4);
    chk("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
